// File: rtl/i2s_receiver.sv
// i2s_receiver
// ------------
// Slave-mode I2S deserializer. The external bit clock, word select and serial
// data are synchronized into the mclk domain; each synchronized sclk rising
// edge shifts one bit in. A change of ws marks the end of a channel word: the
// bit sampled on that edge is the LSB of the channel that is ending. One
// stereo pair is presented per frame with a one-cycle rx_valid strobe.
//
// Optional feature: define I2S_RX_FRAME_CHECK_EN to enable the frame-length
// check that pulses rx_err on any armed word whose bit count is not WIDTH.
// Without the macro rx_err is tied to 0.
//
// Ports:
//   mclk       in          system clock, all state on its rising edge
//   rst_n      in          asynchronous active-low reset
//   sclk       in          I2S bit clock (asynchronous, each level >= 2 mclk)
//   ws         in          word select, 0 = left, 1 = right
//   sd_rx      in          serial data, MSB first, one-bit delay after ws
//   rx_data_l  out [WIDTH] last complete left word
//   rx_data_r  out [WIDTH] last complete right word
//   rx_valid   out         one-mclk pulse when a new L/R pair is presented
//   rx_err     out         one-mclk pulse on a malformed half-frame

module i2s_receiver #(
  parameter int WIDTH = 16
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             ws,
  input  logic             sd_rx,
  output logic [WIDTH-1:0] rx_data_l,
  output logic [WIDTH-1:0] rx_data_r,
  output logic             rx_valid,
  output logic             rx_err
);

  // Bit counter holds 0..WIDTH+1; WIDTH+1 means "more than WIDTH bits seen".
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] WCNT = CW'(WIDTH);
  localparam logic [CW-1:0] SAT  = CW'(WIDTH + 1);

  // sclk gets a third stage for edge detection; ws/sd_rx are sampled at the
  // second stage so they line up with the detected edge.
  logic [2:0]       sclkSync_q;
  logic [1:0]       wsSync_q;
  logic [1:0]       sdSync_q;

  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    bitCnt_q;
  logic             wsPrev_q;
  logic             armed_q;
  logic             lHave_q;
  logic [WIDTH-1:0] dataL_q;
  logic [WIDTH-1:0] dataR_q;
  logic             valid_q;

  logic             rise;
  logic             wsCur;
  logic             bitIn;
  logic             wordEnd;
  logic [CW-1:0]    cntInc_d;
  logic [CW-1:0]    wordCnt;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] word;

  assign rise    = sclkSync_q[1] & ~sclkSync_q[2];
  assign wsCur   = wsSync_q[1];
  assign bitIn   = sdSync_q[1];
  assign wordEnd = rise && (wsCur != wsPrev_q);

  // Next shift/count values for the current edge. The word-end bit is shifted
  // in before the word is formed, and a short word is left-justified so its
  // missing LSBs read as zero.
  always_comb begin
    cntInc_d = (bitCnt_q == SAT) ? SAT : bitCnt_q + CW'(1);
    shreg_d  = (bitCnt_q < WCNT) ? {shreg_q[WIDTH-2:0], bitIn} : shreg_q;
    wordCnt  = (cntInc_d > WCNT) ? WCNT : cntInc_d;
    word     = shreg_d << (WCNT - wordCnt);
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  logic err_q;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= wordEnd && armed_q && (cntInc_d != WCNT);
    end
  end

  assign rx_err = err_q;
`else
  assign rx_err = 1'b0;
`endif

  // Main capture state. The first ws transition after reset only arms the
  // receiver; its partial word is dropped. A right word completes a pair only
  // when a left word was latched since the last pair.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sclkSync_q <= '0;
      wsSync_q   <= '0;
      sdSync_q   <= '0;
      shreg_q    <= '0;
      bitCnt_q   <= '0;
      wsPrev_q   <= 1'b0;
      armed_q    <= 1'b0;
      lHave_q    <= 1'b0;
      dataL_q    <= '0;
      dataR_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      sclkSync_q <= {sclkSync_q[1:0], sclk};
      wsSync_q   <= {wsSync_q[0], ws};
      sdSync_q   <= {sdSync_q[0], sd_rx};
      valid_q    <= 1'b0;
      if (rise) begin
        if (wordEnd) begin
          if (armed_q) begin
            if (!wsPrev_q) begin
              dataL_q <= word;
              lHave_q <= 1'b1;
            end else begin
              dataR_q <= word;
              if (lHave_q) begin
                valid_q <= 1'b1;
                lHave_q <= 1'b0;
              end
            end
          end
          armed_q  <= 1'b1;
          bitCnt_q <= '0;
          shreg_q  <= '0;
          wsPrev_q <= wsCur;
        end else begin
          shreg_q  <= shreg_d;
          bitCnt_q <= cntInc_d;
        end
      end
    end
  end

  assign rx_data_l = dataL_q;
  assign rx_data_r = dataR_q;
  assign rx_valid  = valid_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver
// ---------------
// Directed bench for i2s_receiver (WIDTH=16, sclk = mclk/24). Stimulus pushes
// the expected output pulses into a queue; a monitor on the falling mclk edge
// pops and compares whenever rx_valid or rx_err is high.

module tb_i2s_receiver;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [15:0] l;
    logic [15:0] r;
  } exp_t;

  logic        mclk;
  logic        rst_n;
  logic        sclk;
  logic        ws;
  logic        sd_rx;
  logic [15:0] rx_data_l;
  logic [15:0] rx_data_r;
  logic        rx_valid;
  logic        rx_err;

  int   checks;
  int   failures;
  exp_t expQ[$];
  exp_t expHead;
  logic checkPeriod;
  time  lastValidTime;
  time  tRise;
  time  rLsbRise;

  i2s_receiver #(.WIDTH(16)) dut (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .ws        (ws),
    .sd_rx     (sd_rx),
    .rx_data_l (rx_data_l),
    .rx_data_r (rx_data_r),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err)
  );

  // mclk: period 10 time units
  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // Safety net so the run always ends
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: every output pulse must match the head of the expectation queue
  always @(negedge mclk) begin
    if (rst_n && (rx_valid || rx_err)) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_pulse actual v=%b e=%b l=%h r=%h required=no pulse",
                 rx_valid, rx_err, rx_data_l, rx_data_r);
      end else begin
        expHead = expQ.pop_front();
        if ({rx_valid, rx_err, rx_data_l, rx_data_r} !== {expHead.v, expHead.e, expHead.l, expHead.r}) begin
          failures++;
          $display("[TB] FAIL pulse actual v=%b e=%b l=%h r=%h required v=%b e=%b l=%h r=%h",
                   rx_valid, rx_err, rx_data_l, rx_data_r,
                   expHead.v, expHead.e, expHead.l, expHead.r);
        end
      end
      if (rx_valid) begin
        if (checkPeriod) begin
          checks++;
          if ($time - lastValidTime != 7680) begin
            failures++;
            $display("[TB] FAIL valid_period actual=%0d required=7680", $time - lastValidTime);
          end
        end
        lastValidTime = $time;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // One sclk period: data/ws change while sclk is low, then the rising edge.
  // Entered and left 2 units after an mclk rising edge.
  task automatic applyStimulus(input logic wsVal, input logic bitVal);
    sclk  = 1'b0;
    ws    = wsVal;
    sd_rx = bitVal;
    repeat (12) @(posedge mclk);
    #2 sclk = 1'b1;
    tRise = $time;
    repeat (12) @(posedge mclk);
    #2;
  endtask

  // n bits MSB first; the last bit goes out with ws already at nextWs
  task automatic sendWord(input logic wsVal, input logic [31:0] data, input int n, input logic nextWs);
    for (int i = n - 1; i >= 1; i--) applyStimulus(wsVal, data[i]);
    applyStimulus(nextWs, data[0]);
  endtask

  task automatic sendFrame(input logic [15:0] l, input logic [15:0] r);
    sendWord(1'b0, {16'h0, l}, 16, 1'b1);
    sendWord(1'b1, {16'h0, r}, 16, 1'b0);
  endtask

  task automatic pushExp(input logic v, input logic e, input logic [15:0] l, input logic [15:0] r);
    exp_t x;
    x.v = v; x.e = e; x.l = l; x.r = r;
    expQ.push_back(x);
  endtask

  task automatic pulseReset();
    sclk = 1'b0;
    repeat (4) @(posedge mclk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("reset_data_l", {16'h0, rx_data_l}, 32'h0);
    checkOutput("reset_data_r", {16'h0, rx_data_r}, 32'h0);
    checkOutput("reset_valid_err", {30'h0, rx_valid, rx_err}, 32'h0);
    repeat (3) @(posedge mclk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge mclk);
    #2;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    checkPeriod   = 1'b0;
    lastValidTime = 0;
    tRise         = 0;
    rLsbRise      = 0;
    rst_n = 1'b0;
    sclk  = 1'b0;
    ws    = 1'b0;
    sd_rx = 1'b0;

    repeat (5) @(posedge mclk);
    #2;
    checkOutput("init_data_l", {16'h0, rx_data_l}, 32'h0);
    checkOutput("init_data_r", {16'h0, rx_data_r}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge mclk);
    #2;

    // Partial left arms, silent right, then the first full pair
    sendWord(1'b0, 32'h15, 5, 1'b1);
    sendWord(1'b1, 32'hFFFF, 16, 1'b0);
    checkOutput("silent_r_first", {16'h0, rx_data_r}, 32'hFFFF);
    pushExp(1'b1, 1'b0, 16'h1111, 16'hFFFF);
    sendFrame(16'h1111, 16'hFFFF);
    rLsbRise = tRise;
    checkOutput("valid_latency", 32'(lastValidTime - rLsbRise), 32'd33);

    // Continuous frames, one pair per 768 mclk
    checkPeriod = 1'b1;
    pushExp(1'b1, 1'b0, 16'hA5A5, 16'h5A5A);
    sendFrame(16'hA5A5, 16'h5A5A);
    pushExp(1'b1, 1'b0, 16'h0001, 16'h8000);
    sendFrame(16'h0001, 16'h8000);
    checkPeriod = 1'b0;

    // Short left word: 12 bits of ABC
`ifdef I2S_RX_FRAME_CHECK_EN
    pushExp(1'b0, 1'b1, 16'hABC0, 16'h8000);
`endif
    sendWord(1'b0, 32'hABC, 12, 1'b1);
    checkOutput("short_left", {16'h0, rx_data_l}, 32'hABC0);
    pushExp(1'b1, 1'b0, 16'hABC0, 16'h1357);
    sendWord(1'b1, 32'h1357, 16, 1'b0);

    // Long left word: 20 bits, first 16 are 1234
`ifdef I2S_RX_FRAME_CHECK_EN
    pushExp(1'b0, 1'b1, 16'h1234, 16'h1357);
`endif
    sendWord(1'b0, 32'h1234F, 20, 1'b1);
    checkOutput("long_left", {16'h0, rx_data_l}, 32'h1234);
    pushExp(1'b1, 1'b0, 16'h1234, 16'h2468);
    sendWord(1'b1, 32'h2468, 16, 1'b0);

    // Reset in the middle of a right word
    sendWord(1'b0, 32'hC3C3, 16, 1'b1);
    checkOutput("left_before_reset", {16'h0, rx_data_l}, 32'hC3C3);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, i[0]);
    pulseReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    sendWord(1'b0, 32'h7777, 16, 1'b1);
    sendWord(1'b1, 32'h8888, 16, 1'b0);
    checkOutput("post_reset_silent_r", {16'h0, rx_data_r}, 32'h8888);
    checkOutput("post_reset_l_discarded", {16'h0, rx_data_l}, 32'h0);
    pushExp(1'b1, 1'b0, 16'h0F0F, 16'hF0F0);
    sendFrame(16'h0F0F, 16'hF0F0);

    // Stream starting with ws=1: armed on 0->1, right word silent
    pulseReset();
    applyStimulus(1'b1, 1'b0);
    sendWord(1'b1, 32'hABCD, 16, 1'b0);
    checkOutput("ws1_start_silent_r", {16'h0, rx_data_r}, 32'hABCD);
    checkOutput("ws1_start_l_zero", {16'h0, rx_data_l}, 32'h0);
    pushExp(1'b1, 1'b0, 16'h1E1E, 16'hE1E1);
    sendFrame(16'h1E1E, 16'hE1E1);

    repeat (50) @(posedge mclk);
    checkOutput("queue_drained", expQ.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
